// File: rtl/seq_mult_pkg.sv
// Shared types for the sequential shift-add multiplier.
// Optional feature macro: SEQ_MULT_EARLY_TERM_EN (see seq_mult_datapath).
package seq_mult_pkg;

    localparam int unsigned STATE_W = 2;

    localparam logic [STATE_W-1:0] ST_IDLE_ENC = 2'b00;
    localparam logic [STATE_W-1:0] ST_RUN_ENC  = 2'b01;
    localparam logic [STATE_W-1:0] ST_DONE_ENC = 2'b10;

    typedef enum logic [STATE_W-1:0] {
        IDLE = ST_IDLE_ENC,
        RUN  = ST_RUN_ENC,
        DONE = ST_DONE_ENC
    } state_t;

endpackage

// File: rtl/seq_mult_datapath.sv
// Shift-add datapath: multiplicand/multiplier/accumulator registers and iteration count.
// With SEQ_MULT_EARLY_TERM_EN defined, last_c also fires once no multiplier bits remain.
module seq_mult_datapath
    import seq_mult_pkg::*;
#(
    parameter int unsigned WIDTH_A = 4,
    parameter int unsigned WIDTH_B = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       load,
    input  logic                       step,
    input  logic [WIDTH_A-1:0]         a,
    input  logic [WIDTH_B-1:0]         b,
    output logic [WIDTH_A+WIDTH_B-1:0] acc_next_c,
    output logic                       last_c
);

    localparam int unsigned PW = WIDTH_A + WIDTH_B;
    localparam int unsigned CW = $clog2(WIDTH_B + 1);

    logic [PW-1:0]      mcand;
    logic [PW-1:0]      acc;
    logic [WIDTH_B-1:0] mplier;
    logic [CW-1:0]      count;

    // Accumulator value after the current iteration's conditional add
    assign acc_next_c = mplier[0] ? (acc + mcand) : acc;

`ifdef SEQ_MULT_EARLY_TERM_EN
    logic [WIDTH_B-1:0] mplier_shr_c;
    assign mplier_shr_c = mplier >> 1;
    // Finish when no set multiplier bits remain after this iteration
    assign last_c = (count == CW'(1)) || (mplier_shr_c == '0);
`else
    // Fixed latency: finish on the final of WIDTH_B iterations
    assign last_c = (count == CW'(1));
`endif

    // Operand load on accept, one shift-add iteration per step
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand  <= '0;
            acc    <= '0;
            mplier <= '0;
            count  <= '0;
        end else if (load) begin
            mcand  <= PW'(a);
            acc    <= '0;
            mplier <= b;
            count  <= CW'(WIDTH_B);
        end else if (step) begin
            acc    <= acc_next_c;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count - CW'(1);
        end
    end

endmodule

// File: rtl/seq_multiplier.sv
// Sequential unsigned multiplier with valid/ready operand and product handshakes.
// Optional feature macro: SEQ_MULT_EARLY_TERM_EN (data-dependent latency).
module seq_multiplier
    import seq_mult_pkg::*;
#(
    parameter int unsigned WIDTH_A = 4,
    parameter int unsigned WIDTH_B = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH_A-1:0]         a,
    input  logic [WIDTH_B-1:0]         b,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH_A+WIDTH_B-1:0] product,
    output logic                       busy
);

    localparam int unsigned PW = WIDTH_A + WIDTH_B;

    state_t        state_q;
    state_t        state_d;
    logic          load_c;
    logic          step_c;
    logic          last_c;
    logic [PW-1:0] acc_next_c;

    assign load_c = in_valid & in_ready;
    assign step_c = (state_q == RUN);

    seq_mult_datapath #(
        .WIDTH_A (WIDTH_A),
        .WIDTH_B (WIDTH_B)
    ) u_datapath (
        .clk        (clk),
        .rst        (rst),
        .load       (load_c),
        .step       (step_c),
        .a          (a),
        .b          (b),
        .acc_next_c (acc_next_c),
        .last_c     (last_c)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: accept in IDLE, iterate in RUN, hold result in DONE
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (in_valid)  state_d = RUN;
            RUN:  if (last_c)    state_d = DONE;
            DONE: if (out_ready) state_d = IDLE;
            default:             state_d = IDLE;
        endcase
    end

    // Handshake/status outputs registered from the next state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            in_ready  <= (state_d == IDLE);
            out_valid <= (state_d == DONE);
            busy      <= (state_d != IDLE);
        end
    end

    // Product captured on the final iteration, held until the next result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            product <= '0;
        end else if (step_c && last_c) begin
            product <= acc_next_c;
        end
    end

endmodule
